// File: rtl/layer1_seq_ctrl.sv
// layer1_seq_ctrl: tap sequencer for the first convolution layer.
// Walks N_TILES output tiles of TAPS taps each. Every tap reads one LANES-wide pixel word and the
// four packed kernel weights, then presents them to the PE array two cycles later.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, abort                image request (IDLE only), synchronous abort
//   busy, done                  image in progress, one-cycle completion pulse
//   pic_avail                   picture buffer readable this cycle
//   pic_rd_en/addr/data         picture buffer read port (data one cycle after en)
//   wt_rd_en/addr/data          weight ROM read port (data one cycle after en)
//   picDat, weightDat_0..3      registered PE operands
//   pe_en, pe_first             operands valid, first tap of the tile
//   res_we, res_addr            result capture strobe and tile index
module layer1_seq_ctrl #(
  parameter int unsigned KSIZE   = 5,
  parameter int unsigned DW      = 16,
  parameter int unsigned LANES   = 16,
  parameter int unsigned N_TILES = 36,
  parameter int unsigned RES_LAT = 3,
  parameter int unsigned PADDR_W = 10,
  parameter int unsigned TADDR_W = 5,
  parameter int unsigned RADDR_W = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  input  logic                      pic_avail,
  output logic                      pic_rd_en,
  output logic [PADDR_W-1:0]        pic_rd_addr,
  input  logic [LANES*DW-1:0]       pic_rd_data,
  output logic                      wt_rd_en,
  output logic [TADDR_W-1:0]        wt_rd_addr,
  input  logic [4*DW-1:0]           wt_rd_data,
  output logic [LANES*DW-1:0]       picDat,
  output logic signed [DW-1:0]      weightDat_0,
  output logic signed [DW-1:0]      weightDat_1,
  output logic signed [DW-1:0]      weightDat_2,
  output logic signed [DW-1:0]      weightDat_3,
  output logic                      pe_en,
  output logic                      pe_first,
  output logic                      res_we,
  output logic [RADDR_W-1:0]        res_addr
);

  localparam int unsigned TAPS = KSIZE * KSIZE;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StRun  = 3'd1;
  localparam logic [2:0] StWait = 3'd2;
  localparam logic [2:0] StNext = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [TADDR_W-1:0]  tap_q, tap_d;
  logic [RADDR_W-1:0]  tile_q, tile_d;
  logic [PADDR_W-1:0]  pbase_q, pbase_d;  // tile * TAPS, kept as a running sum
  logic [7:0]          wcnt_q, wcnt_d;

  logic                rd_vld_q, rd_first_q;
  logic                pe_en_q, pe_first_q;
  logic [LANES*DW-1:0] pic_q;
  logic [4*DW-1:0]     wt_q;

  logic rd_fire, last_tap, last_tile, res_fire;

  assign rd_fire   = (state_q == StRun) && pic_avail && !abort;
  assign last_tap  = (tap_q == TADDR_W'(TAPS - 1));
  assign last_tile = (tile_q == RADDR_W'(N_TILES - 1));
  // WAIT is entered one cycle after the last read; the last pe_en appears one cycle later and the
  // result is valid RES_LAT cycles after that.
  assign res_fire  = (state_q == StWait) && (wcnt_q == 8'(RES_LAT + 1)) && !abort;

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    tile_d  = tile_q;
    pbase_d = pbase_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d = StRun;
          tap_d   = '0;
          tile_d  = '0;
          pbase_d = '0;
        end
      end
      StRun: begin
        if (rd_fire) begin
          if (last_tap) begin
            state_d = StWait;
            wcnt_d  = '0;
          end else begin
            tap_d = tap_q + TADDR_W'(1);
          end
        end
      end
      StWait: begin
        wcnt_d = wcnt_q + 8'd1;
        // The final tile's result strobe leads straight to completion.
        if (res_fire) state_d = last_tile ? StDone : StNext;
      end
      StNext: begin
        if (last_tile) begin
          state_d = StDone;
        end else begin
          state_d = StRun;
          tile_d  = tile_q + RADDR_W'(1);
          pbase_d = pbase_q + PADDR_W'(TAPS);
          tap_d   = '0;
        end
      end
      StDone: begin
        state_d = StIdle;
        tap_d   = '0;
        tile_d  = '0;
        pbase_d = '0;
      end
      default: state_d = StIdle;
    endcase
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      tap_d   = '0;
      tile_d  = '0;
      pbase_d = '0;
      wcnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      tap_q   <= '0;
      tile_q  <= '0;
      pbase_q <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      tile_q  <= tile_d;
      pbase_q <= pbase_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Two-stage operand path: read strobe -> memory data -> PE registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q   <= 1'b0;
      rd_first_q <= 1'b0;
      pe_en_q    <= 1'b0;
      pe_first_q <= 1'b0;
      pic_q      <= '0;
      wt_q       <= '0;
    end else begin
      rd_vld_q   <= rd_fire;
      rd_first_q <= rd_fire && (tap_q == '0);
      pe_en_q    <= rd_vld_q && !abort;
      pe_first_q <= rd_vld_q && rd_first_q && !abort;
      if (rd_vld_q && !abort) begin
        pic_q <= pic_rd_data;
        wt_q  <= wt_rd_data;
      end
    end
  end

  assign busy        = (state_q == StRun) || (state_q == StWait) || (state_q == StNext);
  assign done        = (state_q == StDone) && !abort;
  assign pic_rd_en   = rd_fire;
  assign wt_rd_en    = rd_fire;
  assign pic_rd_addr = pbase_q + PADDR_W'(tap_q);
  assign wt_rd_addr  = tap_q;
  assign picDat      = pic_q;
  assign weightDat_0 = wt_q[0*DW +: DW];
  assign weightDat_1 = wt_q[1*DW +: DW];
  assign weightDat_2 = wt_q[2*DW +: DW];
  assign weightDat_3 = wt_q[3*DW +: DW];
  assign pe_en       = pe_en_q;
  assign pe_first    = pe_first_q;
  assign res_we      = res_fire;
  assign res_addr    = tile_q;

endmodule
